instr_sequencer: RTL and testbench

- Multi-cycle fetch/decode/execute sequencer for the bbtron-enhanced core.
- It sits above the opcode decoder and datapath and steps each instruction through its phases.
- It handles the variable-latency handshakes with instruction memory, data memory, the IN port and the OUT port.
- It drives PC, IR and register-file strobes, and manages run/pause, halt and memory-timeout conditions.

---
 rtl/instr_sequencer_pkg.sv | 65 ++++++
 rtl/instr_sequencer_if.sv | 35 +++
 rtl/instr_sequencer_opcode_class_decode.sv | 29 ++
 rtl/instr_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_instr_sequencer.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the bbtron-enhanced instruction sequencer: opcodes,
// FSM state encodings, PC / write-back source codes and opcode classes.
package instr_sequencer_pkg;

    localparam logic [5:0] OP_ADD  = 6'd0;
    localparam logic [5:0] OP_SUB  = 6'd1;
    localparam logic [5:0] OP_AND  = 6'd2;
    localparam logic [5:0] OP_OR   = 6'd3;
    localparam logic [5:0] OP_XOR  = 6'd4;
    localparam logic [5:0] OP_SLL  = 6'd5;
    localparam logic [5:0] OP_SRL  = 6'd6;
    localparam logic [5:0] OP_SLT  = 6'd7;
    localparam logic [5:0] OP_ADDI = 6'd8;
    localparam logic [5:0] OP_BEQ  = 6'd9;
    localparam logic [5:0] OP_BNE  = 6'd10;
    localparam logic [5:0] OP_ANDI = 6'd11;
    localparam logic [5:0] OP_ORI  = 6'd12;
    localparam logic [5:0] OP_XORI = 6'd13;
    localparam logic [5:0] OP_LUI  = 6'd14;
    localparam logic [5:0] OP_LW   = 6'd15;
    localparam logic [5:0] OP_SW   = 6'd16;
    localparam logic [5:0] OP_SRA  = 6'd17;
    localparam logic [5:0] OP_SLTI = 6'd18;
    localparam logic [5:0] OP_MUL  = 6'd19;
    localparam logic [5:0] OP_NOT  = 6'd20;
    localparam logic [5:0] OP_IN   = 6'd21;
    localparam logic [5:0] OP_OUT  = 6'd22;
    localparam logic [5:0] OP_JMP  = 6'd23;
    localparam logic [5:0] OP_NOP  = 6'd24;
    localparam logic [5:0] OP_HLT  = 6'd25;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXEC    = 3'd3,
        ST_MEM     = 3'd4,
        ST_WAIT_IN = 3'd5,
        ST_OUT     = 3'd6,
        ST_HALT    = 3'd7
    } state_e;

    localparam logic [1:0] PC_SRC_INC    = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_IN  = 2'd2;

    typedef enum logic [3:0] {
        CLS_ALU       = 4'd0,
        CLS_BRANCH_EQ = 4'd1,
        CLS_BRANCH_NE = 4'd2,
        CLS_JUMP      = 4'd3,
        CLS_LOAD      = 4'd4,
        CLS_STORE     = 4'd5,
        CLS_IN        = 4'd6,
        CLS_OUT       = 4'd7,
        CLS_NOP       = 4'd8,
        CLS_HALT      = 4'd9,
        CLS_ILLEGAL   = 4'd10
    } op_class_e;

endpackage

// File: rtl/instr_sequencer_if.sv
// Handshake and strobe bundle between the sequencer (master) and the
// datapath / memory / IO side (slave).
interface instr_sequencer_if;

    logic [5:0] opcode;
    logic       alu_zero;
    logic       imem_ready;
    logic       dmem_ready;
    logic       in_valid;
    logic       out_ack;

    logic       imem_req;
    logic       ir_load;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       rf_write;
    logic [1:0] wb_sel;
    logic       dmem_req;
    logic       dmem_we;
    logic       in_ready;
    logic       out_valid;

    modport master (
        input  opcode, alu_zero, imem_ready, dmem_ready, in_valid, out_ack,
        output imem_req, ir_load, pc_write, pc_src, rf_write, wb_sel,
               dmem_req, dmem_we, in_ready, out_valid
    );

    modport slave (
        output opcode, alu_zero, imem_ready, dmem_ready, in_valid, out_ack,
        input  imem_req, ir_load, pc_write, pc_src, rf_write, wb_sel,
               dmem_req, dmem_we, in_ready, out_valid
    );

endinterface

// File: rtl/instr_sequencer_opcode_class_decode.sv
// Purely combinational opcode-to-class mapping; opcodes 26..63 are illegal.
module instr_sequencer_opcode_class_decode
    import instr_sequencer_pkg::*;
(
    input  logic [5:0] opcode,
    output op_class_e  op_class
);

    // Map each opcode to the class that selects its phase sequence
    always_comb begin
        op_class = CLS_ILLEGAL;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SLT,
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
            OP_SRA, OP_SLTI, OP_MUL, OP_NOT: op_class = CLS_ALU;
            OP_BEQ:                          op_class = CLS_BRANCH_EQ;
            OP_BNE:                          op_class = CLS_BRANCH_NE;
            OP_JMP:                          op_class = CLS_JUMP;
            OP_LW:                           op_class = CLS_LOAD;
            OP_SW:                           op_class = CLS_STORE;
            OP_IN:                           op_class = CLS_IN;
            OP_OUT:                          op_class = CLS_OUT;
            OP_NOP:                          op_class = CLS_NOP;
            OP_HLT:                          op_class = CLS_HALT;
            default:                         op_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer: steps instructions through their
// phases, runs the memory/IO handshakes and handles halt and bus timeouts.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int RET_W       = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    run,
    instr_sequencer_if.master       bus,
    output logic                    halted,
    output logic                    bus_err,
    output logic                    illegal_op,
    output logic [RET_W-1:0]        retired,
    output logic [2:0]              state_dbg
);

    localparam int CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_e           state_r;
    state_e           state_nxt_s;
    state_e           done_nxt_s;
    logic [CNT_W-1:0] wait_cnt_r;
    logic [RET_W-1:0] retired_r;
    op_class_e        op_class_s;
    logic             complete_s;
    logic             wait_clr_s;
    logic             wait_inc_s;
    logic             timeout_s;

    instr_sequencer_opcode_class_decode u_class_decode (
        .opcode   (bus.opcode),
        .op_class (op_class_s)
    );

    // Next-state and strobe decode; strobes follow state and handshakes in the same cycle
    always_comb begin
        state_nxt_s   = state_r;
        complete_s    = 1'b0;
        wait_inc_s    = 1'b0;
        bus.imem_req  = 1'b0;
        bus.ir_load   = 1'b0;
        bus.pc_write  = 1'b0;
        bus.pc_src    = PC_SRC_INC;
        bus.rf_write  = 1'b0;
        bus.wb_sel    = WB_ALU;
        bus.dmem_req  = 1'b0;
        bus.dmem_we   = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        halted        = 1'b0;
        bus_err       = 1'b0;
        illegal_op    = 1'b0;
        timeout_s     = (wait_cnt_r == CNT_LAST);
        done_nxt_s    = run ? ST_FETCH : ST_IDLE;

        case (state_r)
            ST_IDLE: begin
                if (run) begin
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                bus.imem_req = 1'b1;
                if (bus.imem_ready) begin
                    bus.ir_load  = 1'b1;
                    bus.pc_write = 1'b1;
                    bus.pc_src   = PC_SRC_INC;
                    state_nxt_s  = ST_DECODE;
                end else if (timeout_s) begin
                    bus_err     = 1'b1;
                    state_nxt_s = ST_HALT;
                end else begin
                    wait_inc_s = 1'b1;
                end
            end
            ST_DECODE: begin
                case (op_class_s)
                    CLS_ALU, CLS_BRANCH_EQ,
                    CLS_BRANCH_NE, CLS_JUMP: state_nxt_s = ST_EXEC;
                    CLS_LOAD, CLS_STORE:     state_nxt_s = ST_MEM;
                    CLS_IN:                  state_nxt_s = ST_WAIT_IN;
                    CLS_OUT:                 state_nxt_s = ST_OUT;
                    CLS_HALT:                state_nxt_s = ST_HALT;
                    CLS_NOP: begin
                        complete_s  = 1'b1;
                        state_nxt_s = done_nxt_s;
                    end
                    CLS_ILLEGAL: begin
                        illegal_op  = 1'b1;
                        complete_s  = 1'b1;
                        state_nxt_s = done_nxt_s;
                    end
                    default: begin
                        complete_s  = 1'b1;
                        state_nxt_s = done_nxt_s;
                    end
                endcase
            end
            ST_EXEC: begin
                case (op_class_s)
                    CLS_ALU: begin
                        bus.rf_write = 1'b1;
                        bus.wb_sel   = WB_ALU;
                    end
                    CLS_BRANCH_EQ: begin
                        bus.pc_write = bus.alu_zero;
                        bus.pc_src   = PC_SRC_BRANCH;
                    end
                    CLS_BRANCH_NE: begin
                        bus.pc_write = ~bus.alu_zero;
                        bus.pc_src   = PC_SRC_BRANCH;
                    end
                    CLS_JUMP: begin
                        bus.pc_write = 1'b1;
                        bus.pc_src   = PC_SRC_JUMP;
                    end
                    default: begin
                        bus.pc_write = 1'b0;
                    end
                endcase
                complete_s  = 1'b1;
                state_nxt_s = done_nxt_s;
            end
            ST_MEM: begin
                bus.dmem_req = 1'b1;
                bus.dmem_we  = (op_class_s == CLS_STORE);
                // A ready arriving on the final allowed cycle still beats the timeout
                if (bus.dmem_ready) begin
                    if (op_class_s == CLS_LOAD) begin
                        bus.rf_write = 1'b1;
                        bus.wb_sel   = WB_MEM;
                    end else begin
                        bus.rf_write = 1'b0;
                    end
                    complete_s  = 1'b1;
                    state_nxt_s = done_nxt_s;
                end else if (timeout_s) begin
                    bus_err     = 1'b1;
                    state_nxt_s = ST_HALT;
                end else begin
                    wait_inc_s = 1'b1;
                end
            end
            ST_WAIT_IN: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    bus.rf_write = 1'b1;
                    bus.wb_sel   = WB_IN;
                    complete_s   = 1'b1;
                    state_nxt_s  = done_nxt_s;
                end else begin
                    state_nxt_s = ST_WAIT_IN;
                end
            end
            ST_OUT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ack) begin
                    complete_s  = 1'b1;
                    state_nxt_s = done_nxt_s;
                end else begin
                    state_nxt_s = ST_OUT;
                end
            end
            ST_HALT: begin
                halted      = 1'b1;
                state_nxt_s = ST_HALT;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        wait_clr_s = (state_nxt_s != state_r) &&
                     ((state_nxt_s == ST_FETCH) || (state_nxt_s == ST_MEM));
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Memory wait counter, restarted on each entry to FETCH or MEM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else if (wait_clr_s) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else if (wait_inc_s) begin
            wait_cnt_r <= wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_r <= {RET_W{1'b0}};
        end else if (complete_s) begin
            retired_r <= retired_r + {{(RET_W-1){1'b0}}, 1'b1};
        end else begin
            retired_r <= retired_r;
        end
    end

    assign retired   = retired_r;
    assign state_dbg = state_r;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: one task per scenario, inline checks
// against hand-computed expectations.
module tb_instr_sequencer;
    import instr_sequencer_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic        halted;
    logic        bus_err;
    logic        illegal_op;
    logic [15:0] retired;
    logic [2:0]  state_dbg;
    logic [14:0] outs_s;
    int          n_cmp;
    int          n_bad;

    instr_sequencer_if bus ();

    instr_sequencer #(.MEM_TIMEOUT(16), .RET_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .bus        (bus),
        .halted     (halted),
        .bus_err    (bus_err),
        .illegal_op (illegal_op),
        .retired    (retired),
        .state_dbg  (state_dbg)
    );

    assign outs_s = {bus.imem_req, bus.ir_load, bus.pc_write, bus.pc_src, bus.rf_write,
                     bus.wb_sel, bus.dmem_req, bus.dmem_we, bus.in_ready, bus.out_valid,
                     halted, bus_err, illegal_op};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; run = 1'b0;
        bus.opcode = 6'd0; bus.alu_zero = 1'b0; bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0; bus.in_valid = 1'b0; bus.out_ack = 1'b0;
        #3 rst_n = 1'b0;
        step(); step();
        n_cmp++; if (state_dbg !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
        n_cmp++; if (retired !== 16'd0) begin n_bad++; $display("FAIL reset_retired: got %0d want 0", retired); end
        n_cmp++; if (outs_s !== 15'd0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", outs_s); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_alu();
        bus.imem_ready = 1'b1; bus.opcode = OP_ADD; run = 1'b1;
        step();
        n_cmp++; if ({bus.imem_req, bus.ir_load, bus.pc_write, bus.pc_src, state_dbg} !== {3'b111, 2'd0, 3'd1}) begin
            n_bad++; $display("FAIL alu_fetch: got %b want 11100001", {bus.imem_req, bus.ir_load, bus.pc_write, bus.pc_src, state_dbg}); end
        step();
        n_cmp++; if ({state_dbg, bus.rf_write} !== {3'd2, 1'b0}) begin
            n_bad++; $display("FAIL alu_decode: got %b want 0100", {state_dbg, bus.rf_write}); end
        step();
        n_cmp++; if ({state_dbg, bus.rf_write, bus.wb_sel} !== {3'd3, 1'b1, 2'd0}) begin
            n_bad++; $display("FAIL alu_exec: got %b want 011100", {state_dbg, bus.rf_write, bus.wb_sel}); end
        run = 1'b0;
        step();
        n_cmp++; if ({state_dbg, retired} !== {3'd0, 16'd1}) begin
            n_bad++; $display("FAIL alu_retire: got state %0d ret %0d want 0 1", state_dbg, retired); end
    endtask

    task automatic test_branch();
        bus.opcode = OP_BEQ; bus.alu_zero = 1'b1; run = 1'b1;
        step(); step(); step();
        n_cmp++; if ({bus.pc_write, bus.pc_src, bus.rf_write} !== {1'b1, 2'd1, 1'b0}) begin
            n_bad++; $display("FAIL beq_taken: got %b want 1010", {bus.pc_write, bus.pc_src, bus.rf_write}); end
        step();
        n_cmp++; if ({state_dbg, retired} !== {3'd1, 16'd2}) begin
            n_bad++; $display("FAIL beq_retire: got state %0d ret %0d want 1 2", state_dbg, retired); end
        bus.opcode = OP_BNE;
        step(); step();
        n_cmp++; if ({state_dbg, bus.pc_write, bus.pc_src} !== {3'd3, 1'b0, 2'd1}) begin
            n_bad++; $display("FAIL bne_not_taken: got %b want 011001", {state_dbg, bus.pc_write, bus.pc_src}); end
        run = 1'b0;
        step();
        n_cmp++; if ({state_dbg, retired} !== {3'd0, 16'd3}) begin
            n_bad++; $display("FAIL bne_retire: got state %0d ret %0d want 0 3", state_dbg, retired); end
        bus.alu_zero = 1'b0;
    endtask

    task automatic test_mem();
        int req_cycles;
        req_cycles = 0;
        bus.opcode = OP_LW; bus.dmem_ready = 1'b0; run = 1'b1;
        step(); step(); step();
        for (int i = 0; i < 6; i++) begin
            if (i == 5) begin bus.dmem_ready = 1'b1; #1; end
            if (bus.dmem_req === 1'b1) req_cycles++;
            if (i < 5) step();
        end
        n_cmp++; if (req_cycles !== 6) begin n_bad++; $display("FAIL lw_req_len: got %0d want 6", req_cycles); end
        n_cmp++; if ({bus.rf_write, bus.wb_sel, bus.dmem_we} !== {1'b1, 2'd1, 1'b0}) begin
            n_bad++; $display("FAIL lw_wb: got %b want 1010", {bus.rf_write, bus.wb_sel, bus.dmem_we}); end
        step();
        n_cmp++; if ({state_dbg, retired} !== {3'd1, 16'd4}) begin
            n_bad++; $display("FAIL lw_retire: got state %0d ret %0d want 1 4", state_dbg, retired); end
        bus.opcode = OP_SW;
        step(); step();
        n_cmp++; if ({bus.dmem_req, bus.dmem_we, bus.rf_write} !== 3'b110) begin
            n_bad++; $display("FAIL sw_strobes: got %b want 110", {bus.dmem_req, bus.dmem_we, bus.rf_write}); end
        run = 1'b0;
        step();
        n_cmp++; if ({state_dbg, retired} !== {3'd0, 16'd5}) begin
            n_bad++; $display("FAIL sw_retire: got state %0d ret %0d want 0 5", state_dbg, retired); end
        bus.dmem_ready = 1'b0;
    endtask

    task automatic test_io();
        int rdy_cycles;
        int val_cycles;
        rdy_cycles = 0; val_cycles = 0;
        bus.opcode = OP_IN; run = 1'b1;
        step(); step(); step();
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin bus.in_valid = 1'b1; #1; end
            if (bus.in_ready === 1'b1) rdy_cycles++;
            if (i < 4) step();
        end
        n_cmp++; if (rdy_cycles !== 5) begin n_bad++; $display("FAIL in_ready_len: got %0d want 5", rdy_cycles); end
        n_cmp++; if ({bus.rf_write, bus.wb_sel} !== {1'b1, 2'd2}) begin
            n_bad++; $display("FAIL in_wb: got %b want 110", {bus.rf_write, bus.wb_sel}); end
        step();
        bus.in_valid = 1'b0; bus.opcode = OP_OUT;
        n_cmp++; if (retired !== 16'd6) begin n_bad++; $display("FAIL in_retire: got %0d want 6", retired); end
        step(); step();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin bus.out_ack = 1'b1; run = 1'b0; #1; end
            if (bus.out_valid === 1'b1 && bus.rf_write === 1'b0) val_cycles++;
            if (i < 3) step();
        end
        n_cmp++; if (val_cycles !== 4) begin n_bad++; $display("FAIL out_valid_held: got %0d want 4", val_cycles); end
        step();
        bus.out_ack = 1'b0;
        n_cmp++; if ({state_dbg, bus.out_valid, retired} !== {3'd0, 1'b0, 16'd7}) begin
            n_bad++; $display("FAIL out_retire: got state %0d ov %0d ret %0d want 0 0 7", state_dbg, bus.out_valid, retired); end
    endtask

    task automatic test_illegal();
        bus.opcode = 6'd40; run = 1'b1;
        step(); step();
        n_cmp++; if ({state_dbg, illegal_op} !== {3'd2, 1'b1}) begin
            n_bad++; $display("FAIL illegal_pulse: got %b want 0101", {state_dbg, illegal_op}); end
        run = 1'b0;
        step();
        n_cmp++; if ({state_dbg, illegal_op, retired} !== {3'd0, 1'b0, 16'd8}) begin
            n_bad++; $display("FAIL illegal_nop: got state %0d ill %0d ret %0d want 0 0 8", state_dbg, illegal_op, retired); end
    endtask

    task automatic test_timeout();
        int err_cycle;
        int err_count;
        err_cycle = 0; err_count = 0;
        bus.imem_ready = 1'b0; run = 1'b1;
        step();
        for (int i = 1; i <= 16; i++) begin
            if (bus_err === 1'b1) begin err_count++; err_cycle = i; end
            if (i < 16) step();
        end
        n_cmp++; if ({err_count, err_cycle} !== {32'd1, 32'd16}) begin
            n_bad++; $display("FAIL bus_err_timing: got count %0d cycle %0d want 1 16", err_count, err_cycle); end
        step();
        n_cmp++; if ({state_dbg, halted, bus_err} !== {3'd7, 1'b1, 1'b0}) begin
            n_bad++; $display("FAIL timeout_halt: got %b want 11110", {state_dbg, halted, bus_err}); end
        bus.imem_ready = 1'b1;
        step(); step(); step();
        n_cmp++; if ({state_dbg, halted, bus.imem_req, retired} !== {3'd7, 1'b1, 1'b0, 16'd8}) begin
            n_bad++; $display("FAIL halt_sticky: got state %0d h %0d req %0d ret %0d want 7 1 0 8", state_dbg, halted, bus.imem_req, retired); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({state_dbg, retired, outs_s} !== {3'd0, 16'd0, 15'd0}) begin
            n_bad++; $display("FAIL halt_reset: got state %0d ret %0d outs %h want 0 0 0", state_dbg, retired, outs_s); end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_hlt_op();
        bus.opcode = OP_HLT; run = 1'b1;
        step(); step(); step();
        n_cmp++; if ({state_dbg, halted, retired} !== {3'd7, 1'b1, 16'd0}) begin
            n_bad++; $display("FAIL hlt_op: got state %0d h %0d ret %0d want 7 1 0", state_dbg, halted, retired); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid_mem();
        bus.opcode = OP_SW; bus.dmem_ready = 1'b0; run = 1'b1;
        step(); step(); step();
        n_cmp++; if ({state_dbg, bus.dmem_req, bus.dmem_we} !== {3'd4, 1'b1, 1'b1}) begin
            n_bad++; $display("FAIL sw_pending: got %b want 10011", {state_dbg, bus.dmem_req, bus.dmem_we}); end
        rst_n = 1'b0;
        step();
        n_cmp++; if ({state_dbg, outs_s} !== {3'd0, 15'd0}) begin
            n_bad++; $display("FAIL reset_mid_mem: got state %0d outs %h want 0 0", state_dbg, outs_s); end
        rst_n = 1'b1; run = 1'b0;
        step();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_alu();
        test_branch();
        test_mem();
        test_io();
        test_illegal();
        test_timeout();
        test_hlt_op();
        test_reset_mid_mem();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
